complex_accum: RTL and testbench

- Streaming complex accumulator placed directly downstream of the complex multiplier in the amplitude datapath.
- Consumes a stream of complex products, one per cycle, in the same signed fixed-point format (complex_bit total, fp_bit fractional; Q1.22 at defaults).
- Sums each vector of products, delimited by in_last, in a guard-bit-extended accumulator.
- Emits one saturated complex result per vector through a valid/ready output handshake.

---
 rtl/complex_accum_pkg.sv | 20 ++
 rtl/complex_accum_cplx_sat.sv | 37 +++
 rtl/complex_accum.sv | 120 ++++++++++++
 tb/tb_complex_accum.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_accum_pkg.sv
// Shared types and default constants for the complex accumulator datapath.
package complex_accum_pkg;

    localparam int COMPLEX_BIT = 24;
    localparam int FP_BIT      = 22;
    localparam int GUARD_BIT   = 8;

    localparam logic [COMPLEX_BIT-1:0] ONE = 24'h400000;

    typedef struct packed {
        logic signed [COMPLEX_BIT-1:0] r;
        logic signed [COMPLEX_BIT-1:0] i;
    } complex_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/complex_accum_cplx_sat.sv
// Narrows a guard-extended complex sum to component width, clamping each
// component independently and flagging which ones were clamped.
module cplx_sat
    import complex_accum_pkg::*;
#(
    parameter int complex_bit = COMPLEX_BIT,
    parameter int guard_bit   = GUARD_BIT
) (
    input  logic [complex_bit+guard_bit-1:0] acc_r,
    input  logic [complex_bit+guard_bit-1:0] acc_i,
    output logic [complex_bit-1:0]           sat_r,
    output logic [complex_bit-1:0]           sat_i,
    output logic                             clamp_r,
    output logic                             clamp_i
);

    localparam int ACC_W = complex_bit + guard_bit;
    localparam logic [complex_bit-1:0] MAX_V = {1'b0, {(complex_bit-1){1'b1}}};
    localparam logic [complex_bit-1:0] MIN_V = {1'b1, {(complex_bit-1){1'b0}}};

    // The value fits when every bit above the result's sign bit copies the sign.
    function automatic logic [complex_bit:0] narrow(input logic [ACC_W-1:0] v);
        logic [guard_bit:0] head;
        head = v[ACC_W-1:complex_bit-1];
        if (head == '0 || head == '1) begin
            return {1'b0, v[complex_bit-1:0]};
        end else if (v[ACC_W-1]) begin
            return {1'b1, MIN_V};
        end else begin
            return {1'b1, MAX_V};
        end
    endfunction

    assign {clamp_r, sat_r} = narrow(acc_r);
    assign {clamp_i, sat_i} = narrow(acc_i);

endmodule

// File: rtl/complex_accum.sv
// Streaming complex accumulator: sums in_last-delimited vectors of complex
// products and emits one saturated result per vector over valid/ready.
module complex_accum
    import complex_accum_pkg::*;
#(
    parameter int complex_bit = COMPLEX_BIT,
    parameter int fp_bit      = FP_BIT,
    parameter int guard_bit   = GUARD_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [complex_bit-1:0] in_r,
    input  logic [complex_bit-1:0] in_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [complex_bit-1:0] out_r,
    output logic [complex_bit-1:0] out_i,
    output logic                   out_sat,
    output logic                   out_trunc,
    output logic [guard_bit:0]     out_count
);

    localparam int ACC_W = complex_bit + guard_bit;
    localparam logic [guard_bit:0] LAST_IDX = {1'b0, {guard_bit{1'b1}}};
    localparam logic [guard_bit:0] CNT_ONE  = (guard_bit+1)'(1);

    if (fp_bit < 0 || fp_bit >= complex_bit || guard_bit < 1) begin : g_bad_cfg
        $error("complex_accum: fp_bit must lie inside the word and guard_bit must be >= 1");
    end

    state_t                 state;
    logic [ACC_W-1:0]       acc_r;
    logic [ACC_W-1:0]       acc_i;
    logic [ACC_W-1:0]       ext_r;
    logic [ACC_W-1:0]       ext_i;
    logic [ACC_W-1:0]       sum_r;
    logic [ACC_W-1:0]       sum_i;
    logic [guard_bit:0]     count;
    logic                   accept;
    logic                   closing;
    logic [complex_bit-1:0] sat_r;
    logic [complex_bit-1:0] sat_i;
    logic                   clamp_r;
    logic                   clamp_i;

    // Handshakes: a transfer happens on a side when its valid and ready are both
    // high at a rising edge; a held result blocks input until it is taken.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign closing  = accept && (in_last || count == LAST_IDX);

    assign ext_r = {{guard_bit{in_r[complex_bit-1]}}, in_r};
    assign ext_i = {{guard_bit{in_i[complex_bit-1]}}, in_i};
    assign sum_r = acc_r + ext_r;
    assign sum_i = acc_i + ext_i;

    cplx_sat #(
        .complex_bit(complex_bit),
        .guard_bit  (guard_bit)
    ) u_sat (
        .acc_r  (sum_r),
        .acc_i  (sum_i),
        .sat_r  (sat_r),
        .sat_i  (sat_i),
        .clamp_r(clamp_r),
        .clamp_i(clamp_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc_r     <= '0;
            acc_i     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (closing) begin
                // A closing term may arrive with the previous result leaving,
                // so the new result simply overwrites and valid stays high.
                out_valid <= 1'b1;
                out_r     <= sat_r;
                out_i     <= sat_i;
                out_sat   <= clamp_r || clamp_i;
                out_trunc <= !in_last;
                out_count <= count + CNT_ONE;
                acc_r     <= '0;
                acc_i     <= '0;
                count     <= '0;
                state     <= ST_IDLE;
            end else if (accept) begin
                case (state)
                    ST_IDLE: begin
                        acc_r <= ext_r;
                        acc_i <= ext_i;
                        count <= CNT_ONE;
                        state <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        acc_r <= sum_r;
                        acc_i <= sum_i;
                        count <= count + CNT_ONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_complex_accum.sv
// Randomized and directed bench for complex_accum against a plain-arithmetic
// vector-sum model, plus a small-guard instance for the forced-close path.
module tb_complex_accum;
    import complex_accum_pkg::*;

    localparam int CB  = 24;
    localparam int GB  = 8;
    localparam int GB2 = 2;
    localparam int RW  = 2*CB + 2 + GB + 1;

    logic clk = 1'b0;
    logic rst;

    logic          in_valid, in_ready, in_last, out_valid, out_ready;
    logic [CB-1:0] in_r, in_i, out_r, out_i;
    logic          out_sat, out_trunc;
    logic [GB:0]   out_count;

    logic          g_in_valid, g_in_ready, g_in_last, g_out_valid, g_out_ready;
    logic [CB-1:0] g_in_r, g_in_i, g_out_r, g_out_i;
    logic          g_out_sat, g_out_trunc;
    logic [GB2:0]  g_out_count;

    always #5 clk = ~clk;

    complex_accum dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_sat(out_sat),
        .out_trunc(out_trunc), .out_count(out_count)
    );

    complex_accum #(.guard_bit(GB2)) dut_g2 (
        .clk(clk), .rst(rst),
        .in_valid(g_in_valid), .in_ready(g_in_ready), .in_last(g_in_last),
        .in_r(g_in_r), .in_i(g_in_i),
        .out_valid(g_out_valid), .out_ready(g_out_ready),
        .out_r(g_out_r), .out_i(g_out_i), .out_sat(g_out_sat),
        .out_trunc(g_out_trunc), .out_count(g_out_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [CB-1:0] clamp(input longint v, output logic c);
        longint hi, lo;
        hi = (longint'(1) <<< (CB-1)) - 1;
        lo = -(longint'(1) <<< (CB-1));
        c = 1'b1;
        if (v > hi) return hi[CB-1:0];
        if (v < lo) return lo[CB-1:0];
        c = 1'b0;
        return v[CB-1:0];
    endfunction

    function automatic logic [RW-1:0] model_result(input longint sr, input longint si,
                                                   input int n, input logic trunc);
        logic [CB-1:0] r, i;
        logic cr, ci;
        r = clamp(sr, cr);
        i = clamp(si, ci);
        return {r, i, cr | ci, trunc, (GB+1)'(n)};
    endfunction

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] m_exp;
    longint        m_r = 0, m_i = 0;
    int            m_n = 0;
    logic          m_ready;
    logic          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid_model", out_valid, exp_q.size() != 0);
            m_ready = (exp_q.size() == 0) || out_ready;
            check("in_ready_rule", in_ready, m_ready);
            if (rst) begin
                exp_q.delete();
                m_r = 0; m_i = 0; m_n = 0;
            end else begin
                if (exp_q.size() != 0 && out_ready) begin
                    m_exp = exp_q.pop_front();
                    check("result", {out_r, out_i, out_sat, out_trunc, out_count}, m_exp);
                end
                if (in_valid && m_ready) begin
                    m_r += longint'($signed(in_r));
                    m_i += longint'($signed(in_i));
                    m_n++;
                    if (in_last || m_n == (1 << GB)) begin
                        exp_q.push_back(model_result(m_r, m_i, m_n, !in_last));
                        m_r = 0; m_i = 0; m_n = 0;
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [CB-1:0] r, input logic [CB-1:0] i, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1; in_r = r; in_i = i; in_last = last;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            stalls++; t++;
            @(negedge clk);
        end
        if (t >= 50) check("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [CB-1:0] r, input logic [CB-1:0] i,
                             input logic sat, input logic trunc, input int cnt);
        check(tag, {out_valid, out_r, out_i, out_sat, out_trunc, out_count},
              {1'b1, r, i, sat, trunc, (GB+1)'(cnt)});
    endtask

    function automatic logic [CB-1:0] rand_term();
        case ($urandom_range(0, 3))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return CB'($urandom);
            default: return CB'($urandom_range(0, 255)) - 24'd128;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b1;
        g_in_valid = 1'b0; g_in_last = 1'b0; g_in_r = '0; g_in_i = '0; g_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", {out_valid, out_r, out_i, out_sat, out_trunc, out_count}, '0);
        check("reset_g2_valid", g_out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // single-term vector closes from idle, result one cycle later
        send(ONE, 24'hC00000, 1'b1);
        @(negedge clk);
        check_out("single_term", ONE, 24'hC00000, 1'b0, 1'b0, 1);
        @(posedge clk); #1;

        // four back-to-back terms
        stalls = 0;
        for (int k = 0; k < 4; k++) send(24'h100000, 24'h000000, k == 3);
        check("four_no_stall", stalls, 0);
        @(negedge clk);
        check_out("four_terms", ONE, 24'h000000, 1'b0, 1'b0, 4);
        @(posedge clk); #1;

        // saturation in both directions, then a clean vector
        for (int k = 0; k < 3; k++) send(24'h7FFFFF, 24'h800000, k == 2);
        @(negedge clk);
        check_out("sat_clamp", 24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 3);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) send(24'h200000, 24'h200000, k == 1);
        @(negedge clk);
        check_out("sat_clear", ONE, ONE, 1'b0, 1'b0, 2);
        @(posedge clk); #1;

        // backpressure: result held, input blocked
        out_ready = 1'b0;
        send(24'h000100, 24'h000000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_out("hold_stable", 24'h000100, 24'h000000, 1'b0, 1'b0, 1);
            check("hold_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_r = 24'h000010; in_i = '0; in_last = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check_out("release_result", 24'h000010, 24'h000000, 1'b0, 1'b0, 1);
        @(posedge clk); #1;

        // reset mid-vector discards partial sum
        send(24'h100000, 24'h000000, 1'b0);
        send(24'h100000, 24'h000000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", out_valid, 1'b0);
        @(posedge clk); #1;
        send(24'h000001, 24'h000000, 1'b1);
        @(negedge clk);
        check_out("after_reset", 24'h000001, 24'h000000, 1'b0, 1'b0, 1);
        @(posedge clk); #1;

        // forced close on the small-guard instance
        for (int k = 0; k < 4; k++) begin
            g_in_valid = 1'b1; g_in_r = 24'h100000; g_in_i = '0; g_in_last = 1'b0;
            @(negedge clk);
            check("g2_in_ready", g_in_ready, 1'b1);
            check("g2_no_early_out", g_out_valid, 1'b0);
            @(posedge clk); #1;
        end
        g_in_r = 24'h000020; g_in_last = 1'b1;
        @(negedge clk);
        check("g2_forced", {g_out_valid, g_out_r, g_out_i, g_out_sat, g_out_trunc, g_out_count},
              {1'b1, ONE, 24'h000000, 1'b0, 1'b1, 3'd4});
        @(posedge clk); #1;
        g_in_valid = 1'b0; g_in_last = 1'b0;
        @(negedge clk);
        check("g2_next_vector", {g_out_valid, g_out_r, g_out_trunc, g_out_count},
              {1'b1, 24'h000020, 1'b0, 3'd1});
        @(posedge clk); #1;

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_r      = rand_term();
            in_i      = rand_term();
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
